fb_pixel_writer: RTL and testbench

//  Pixel sink for render_module: takes its per-cycle pixel strobes (x, y, enable) and

---
 rtl/gpu_pkg.sv | 29 ++
 rtl/fb_pixel_writer_fifo.sv | 51 +++++
 rtl/fb_pixel_writer.sv | 213 +++++++++++++++++++++
 tb/tb_fb_pixel_writer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared frame-buffer geometry and types for the pixel writer and its write FIFO.
// The frame is 320x240 at 1bpp, packed 32 pixels per SRAM word, row-major.
package gpu_pkg;

   localparam int XWIDTH        = 320;
   localparam int YWIDTH        = 240;
   localparam int WORDS_PER_ROW = XWIDTH / 32;
   localparam int FB_WORDS      = WORDS_PER_ROW * YWIDTH;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_CLEAR_DRAIN,
      ST_CLEAR
   } fbw_state_t;

   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] bits;
   } fb_entry_t;

   // y*10 as two shifts keeps the address path free of a multiplier.
   function automatic logic [11:0] word_addr(input logic [8:0] x, input logic [7:0] y);
      logic [11:0] y_ext;
      y_ext = {4'd0, y};
      return (y_ext << 3) + (y_ext << 1) + {8'd0, x[8:5]};
   endfunction

endpackage

// File: rtl/fb_pixel_writer_fifo.sv
// Pending-write FIFO: DEPTH combined word entries between the combiner and the SRAM port.
// A push while full is ignored; the caller decides what that means.
module fb_write_fifo
   import gpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      n_rst,
   input  logic      push,
   input  fb_entry_t push_data,
   input  logic      pop,
   output fb_entry_t pop_data,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);

   fb_entry_t      mem_q [DEPTH];
   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;
   logic           do_push, do_pop;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/fb_pixel_writer.sv
// Pixel sink: merges strobes that hit the same frame-buffer word, queues masked word
// writes to SRAM behind a ready handshake, and performs whole-buffer clears.
module fb_pixel_writer
   import gpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        enable,
   input  logic [8:0]  x,
   input  logic [7:0]  y,
   input  logic        render_done,
   input  logic        clear_req,
   output logic [11:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [31:0] mem_wmask,
   output logic        mem_write,
   input  logic        mem_ready,
   output logic        flush_done,
   output logic        clear_done,
   output logic        overflow
);

   fbw_state_t  state_q, state_d;
   logic        cmb_valid_q, cmb_valid_d;
   logic [11:0] cmb_addr_q, cmb_addr_d;
   logic [31:0] cmb_bits_q, cmb_bits_d;
   logic        cmb_flush_q, cmb_flush_d;
   logic        clear_pend_q, clear_pend_d;
   logic [11:0] clr_cnt_q, clr_cnt_d;
   logic [11:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] mem_wmask_q, mem_wmask_d;
   logic        mem_write_q, mem_write_d;
   logic        flush_done_q, flush_done_d;
   logic        clear_done_q, clear_done_d;
   logic        overflow_q, overflow_d;

   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   fb_entry_t   fifo_in, fifo_out;

   logic        pix_in_range, pix_acc, accepting, idle_evt, do_flush, out_free;
   logic [11:0] pix_addr;
   logic [31:0] pix_bit;

   assign pix_in_range = (x < 9'(XWIDTH)) && (y < 8'(YWIDTH));
   assign pix_addr     = word_addr(x, y);
   assign pix_bit      = 32'd1 << x[4:0];
   assign accepting    = (state_q == ST_IDLE) || (state_q == ST_FLUSH);
   assign pix_acc      = enable && pix_in_range && accepting;
   assign idle_evt     = (state_q == ST_IDLE) && (render_done || clear_req);
   // cmb_flush_q marks a pre-flush pixel that could not share the flush-cycle push.
   assign do_flush     = idle_evt || cmb_flush_q || (state_q == ST_CLEAR_DRAIN);
   assign out_free     = !mem_write_q || mem_ready;

   fb_write_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .n_rst     (n_rst),
      .push      (fifo_push),
      .push_data (fifo_in),
      .pop       (fifo_pop),
      .pop_data  (fifo_out),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // NOTE: every variable gets a default first so no path through the block infers a latch.
   always_comb begin
      state_d      = state_q;
      cmb_valid_d  = cmb_valid_q;
      cmb_addr_d   = cmb_addr_q;
      cmb_bits_d   = cmb_bits_q;
      cmb_flush_d  = cmb_flush_q;
      clear_pend_d = clear_pend_q;
      clr_cnt_d    = clr_cnt_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wmask_d  = mem_wmask_q;
      mem_write_d  = mem_write_q;
      flush_done_d = 1'b0;
      clear_done_d = 1'b0;
      overflow_d   = overflow_q;
      fifo_push    = 1'b0;
      fifo_pop     = 1'b0;
      fifo_in      = '0;

      if (enable && pix_in_range && !accepting) overflow_d = 1'b1;

      if (pix_acc) begin
         if (cmb_valid_q && (cmb_addr_q == pix_addr)) begin
            cmb_bits_d = cmb_bits_q | pix_bit;
            if (do_flush) begin
               fifo_push   = 1'b1;
               fifo_in     = '{addr: cmb_addr_q, bits: cmb_bits_q | pix_bit};
               cmb_valid_d = 1'b0;
               cmb_flush_d = 1'b0;
            end
         end else begin
            if (cmb_valid_q) begin
               fifo_push = 1'b1;
               fifo_in   = '{addr: cmb_addr_q, bits: cmb_bits_q};
            end
            cmb_valid_d = 1'b1;
            cmb_addr_d  = pix_addr;
            cmb_bits_d  = pix_bit;
            cmb_flush_d = idle_evt;
         end
      end else if (do_flush && cmb_valid_q) begin
         fifo_push   = 1'b1;
         fifo_in     = '{addr: cmb_addr_q, bits: cmb_bits_q};
         cmb_valid_d = 1'b0;
         cmb_flush_d = 1'b0;
      end

      if (fifo_push && fifo_full) overflow_d = 1'b1;

      // Output stage reloads on acceptance, so back-to-back writes need no bubble.
      if (out_free) begin
         mem_write_d = 1'b0;
         if (state_q == ST_CLEAR) begin
            if (clr_cnt_q < 12'(FB_WORDS)) begin
               mem_write_d = 1'b1;
               mem_addr_d  = clr_cnt_q;
               mem_wdata_d = '0;
               mem_wmask_d = '1;
               clr_cnt_d   = clr_cnt_q + 12'd1;
            end
         end else if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            mem_write_d = 1'b1;
            mem_addr_d  = fifo_out.addr;
            mem_wdata_d = fifo_out.bits;
            mem_wmask_d = fifo_out.bits;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (render_done) begin
               state_d      = ST_FLUSH;
               clear_pend_d = clear_req;
            end else if (clear_req) begin
               state_d = ST_CLEAR_DRAIN;
            end
         end
         ST_FLUSH: begin
            if (clear_req) clear_pend_d = 1'b1;
            if (fifo_empty && !mem_write_q && !cmb_flush_q && !fifo_push) begin
               flush_done_d = 1'b1;
               clear_pend_d = 1'b0;
               state_d      = (clear_pend_q || clear_req) ? ST_CLEAR_DRAIN : ST_IDLE;
            end
         end
         ST_CLEAR_DRAIN: begin
            clr_cnt_d = '0;
            if (fifo_empty && !mem_write_q && !cmb_valid_q && !fifo_push) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (mem_write_q && mem_ready && (mem_addr_q == 12'(FB_WORDS - 1))) begin
               clear_done_d = 1'b1;
               overflow_d   = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= ST_IDLE;
         cmb_valid_q  <= 1'b0;
         cmb_addr_q   <= '0;
         cmb_bits_q   <= '0;
         cmb_flush_q  <= 1'b0;
         clear_pend_q <= 1'b0;
         clr_cnt_q    <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wmask_q  <= '0;
         mem_write_q  <= 1'b0;
         flush_done_q <= 1'b0;
         clear_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmb_valid_q  <= cmb_valid_d;
         cmb_addr_q   <= cmb_addr_d;
         cmb_bits_q   <= cmb_bits_d;
         cmb_flush_q  <= cmb_flush_d;
         clear_pend_q <= clear_pend_d;
         clr_cnt_q    <= clr_cnt_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wmask_q  <= mem_wmask_d;
         mem_write_q  <= mem_write_d;
         flush_done_q <= flush_done_d;
         clear_done_q <= clear_done_d;
         overflow_q   <= overflow_d;
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wmask  = mem_wmask_q;
   assign mem_write  = mem_write_q;
   assign flush_done = flush_done_q;
   assign clear_done = clear_done_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer: stimulus queues expected SRAM writes, a negedge
// monitor pops and compares each accepted write and counts done pulses.
module tb_fb_pixel_writer;
   import gpu_pkg::*;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] data;
      logic [31:0] mask;
   } wr_t;

   logic        clk = 1'b0;
   logic        n_rst, enable, render_done, clear_req, mem_ready;
   logic [8:0]  x;
   logic [7:0]  y;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata, mem_wmask;
   logic        mem_write, flush_done, clear_done, overflow;

   int  total = 0, bad = 0;
   int  flush_cnt = 0, clear_cnt = 0, wr_cnt = 0;
   int  ready_mode = 0;
   bit  ignore_wr = 1'b0;
   wr_t exp_q[$];

   fb_pixel_writer #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .enable      (enable),
      .x           (x),
      .y           (y),
      .render_done (render_done),
      .clear_req   (clear_req),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wmask   (mem_wmask),
      .mem_write   (mem_write),
      .mem_ready   (mem_ready),
      .flush_done  (flush_done),
      .clear_done  (clear_done),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit en, input int px, input int py, input bit rd, input bit cr);
      enable      = en;
      x           = 9'(px);
      y           = 8'(py);
      render_done = rd;
      clear_req   = cr;
      tick();
      enable      = 1'b0;
      render_done = 1'b0;
      clear_req   = 1'b0;
   endtask

   task automatic expect_wr(input int addr, input logic [31:0] data, input logic [31:0] mask);
      exp_q.push_back('{addr: 12'(addr), data: data, mask: mask});
   endtask

   task automatic wait_flush(input string name, input int budget);
      int start = flush_cnt;
      int n = 0;
      while (flush_cnt == start && n < budget) begin
         tick();
         n++;
      end
      repeat (4) tick();
      check(name, 76'(flush_cnt - start), 76'd1);
   endtask

   task automatic wait_clear(input string name, input int budget);
      int start = clear_cnt;
      int n = 0;
      while (clear_cnt == start && n < budget) begin
         tick();
         n++;
      end
      repeat (4) tick();
      check(name, 76'(clear_cnt - start), 76'd1);
   endtask

   // SRAM ready driver: 0 = always ready, 1 = toggling, 2 = stalled.
   initial forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       mem_ready = 1'b1;
         1:       mem_ready = ~mem_ready;
         default: mem_ready = 1'b0;
      endcase
   end

   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (n_rst) begin
            if (flush_done) flush_cnt++;
            if (clear_done) clear_cnt++;
            if (mem_write && mem_ready && !ignore_wr) begin
               wr_cnt++;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_write: got addr=%h data=%h mask=%h expected none",
                           mem_addr, mem_wdata, mem_wmask);
               end else begin
                  e = exp_q.pop_front();
                  check("write", {mem_addr, mem_wdata, mem_wmask}, e);
               end
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int w0;
      n_rst = 1'b0; enable = 1'b0; x = '0; y = '0;
      render_done = 1'b0; clear_req = 1'b0; mem_ready = 1'b0;
      #12;
      check("rst_mem_write", 76'(mem_write), 76'd0);
      check("rst_flush_done", 76'(flush_done), 76'd0);
      check("rst_clear_done", 76'(clear_done), 76'd0);
      check("rst_overflow", 76'(overflow), 76'd0);
      check("rst_mem_addr", 76'(mem_addr), 76'd0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      tick();

      // Three adjacent pixels combine into one word write.
      ready_mode = 0;
      w0 = wr_cnt;
      expect_wr(100, 32'h0000_1C00, 32'h0000_1C00);
      drive(1, 10, 10, 0, 0);
      drive(1, 11, 10, 0, 0);
      drive(1, 12, 10, 0, 0);
      drive(0, 0, 0, 1, 0);
      wait_flush("t2_flush_done", 50);
      check("t2_write_count", 76'(wr_cnt - w0), 76'd1);
      check("t2_queue_empty", 76'(exp_q.size()), 76'd0);

      // Out-of-range pixel is ignored; a pixel coincident with render_done merges.
      w0 = wr_cnt;
      drive(1, 320, 0, 0, 0);
      repeat (4) tick();
      check("t6_oob_no_write", 76'(wr_cnt - w0), 76'd0);
      expect_wr(0, 32'h0000_000C, 32'h0000_000C);
      drive(1, 2, 0, 0, 0);
      drive(1, 3, 0, 1, 0);
      wait_flush("t6_flush_done", 50);
      check("t6_write_count", 76'(wr_cnt - w0), 76'd1);
      check("t6_overflow", 76'(overflow), 76'd0);

      // Vertical line at full rate.
      w0 = wr_cnt;
      for (int i = 0; i < 240; i++) begin
         expect_wr(i * 10 + 4, 32'h8000_0000, 32'h8000_0000);
         drive(1, 159, i, 0, 0);
      end
      drive(0, 0, 0, 1, 0);
      wait_flush("t3_flush_done", 100);
      check("t3_write_count", 76'(wr_cnt - w0), 76'd240);
      check("t3_queue_empty", 76'(exp_q.size()), 76'd0);
      check("t3_overflow", 76'(overflow), 76'd0);

      // Stalled SRAM during an 8-pixel line: later entries drop, earlier ones stay ordered.
      ready_mode = 2;
      mem_ready  = 1'b0;
      w0 = wr_cnt;
      for (int i = 0; i < 8; i++) begin
         expect_wr(i * 10, 32'h0000_0001, 32'h0000_0001);
         drive(1, 0, i, 0, 0);
      end
      drive(0, 0, 0, 1, 0);
      repeat (3) tick();
      check("t4_stalled_no_write", 76'(wr_cnt - w0), 76'd0);
      check("t4_overflow_set", 76'(overflow), 76'd1);
      ready_mode = 0;
      wait_flush("t4_flush_done", 100);
      check("t4_prefix_len", 76'((wr_cnt - w0 >= DEPTH) && (wr_cnt - w0 < 8)), 76'd1);
      check("t4_overflow_sticky", 76'(overflow), 76'd1);
      exp_q.delete();

      // Full clear with a 50% ready pattern.
      ready_mode = 1;
      w0 = wr_cnt;
      for (int i = 0; i < FB_WORDS; i++) expect_wr(i, 32'h0, 32'hFFFF_FFFF);
      drive(0, 0, 0, 0, 1);
      wait_clear("t5_clear_done", 10000);
      check("t5_write_count", 76'(wr_cnt - w0), 76'(FB_WORDS));
      check("t5_queue_empty", 76'(exp_q.size()), 76'd0);
      check("t5_overflow_cleared", 76'(overflow), 76'd0);

      // Reset in the middle of a clear, with overflow set by a dropped pixel.
      ignore_wr = 1'b1;
      drive(0, 0, 0, 0, 1);
      repeat (40) tick();
      drive(1, 5, 5, 0, 0);
      tick();
      check("t1_overflow_in_clear", 76'(overflow), 76'd1);
      #2;
      n_rst = 1'b0;
      #1;
      check("t1_rst_mem_write", 76'(mem_write), 76'd0);
      check("t1_rst_mem_addr", 76'(mem_addr), 76'd0);
      check("t1_rst_mem_wmask", 76'(mem_wmask), 76'd0);
      check("t1_rst_overflow", 76'(overflow), 76'd0);
      check("t1_rst_clear_done", 76'(clear_done), 76'd0);
      @(posedge clk);
      #1;
      n_rst      = 1'b1;
      ready_mode = 0;
      exp_q.delete();
      ignore_wr  = 1'b0;
      w0 = wr_cnt;
      expect_wr(11, 32'h0000_0100, 32'h0000_0100);
      drive(1, 40, 1, 0, 0);
      drive(0, 0, 0, 1, 0);
      wait_flush("t1_post_flush_done", 50);
      check("t1_post_write_count", 76'(wr_cnt - w0), 76'd1);
      check("t1_post_queue_empty", 76'(exp_q.size()), 76'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
